// File: rtl/conv2d_kxk_stream.sv
// Streaming KxK "valid" 2-D convolution. Raster pixels in, one saturated
// result per fully covered window out, two register stages after the window.
// Weights are double-buffered (shadow/active); active and the ReLU flag are
// latched on the first pixel of each frame.
module conv2d_kxk_stream #(
  parameter int K      = 5,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int O_SAT  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic [I_W-1:0]    iW,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic              iWren,
  input  logic [I_X-1:0]    iX,
  input  logic              iValid,
  input  logic              iSOF,
  input  logic              iRelu,
  output logic [O_SAT-1:0]  oY,
  output logic              oValid,
  output logic              oFrameDone
);
  localparam int NT     = K * K;
  localparam int PW     = I_X + I_W;
  localparam int ACC_W  = PW + $clog2(NT);
  // one guard bit beyond both widths keeps every extension non-empty
  localparam int EXT_W  = ((ACC_W > O_SAT) ? ACC_W : O_SAT) + 1;
  localparam int RW     = $clog2(IMG_H);
  localparam int CW     = $clog2(IMG_W);
  localparam int STAGES = 2;
  localparam logic signed [EXT_W-1:0] SMAX = {{(EXT_W-O_SAT+1){1'b0}}, {(O_SAT-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SMIN = ~SMAX;

  logic [RW-1:0] row_q, row_d, pos_r;
  logic [CW-1:0] col_q, col_d, pos_c;
  logic          frame_start, win_pos, last_pos;

  logic [K-2:0][IMG_W-1:0][I_X-1:0] line_q;
  logic [K-2:0][I_X-1:0]            line_in;
  logic [K-1:0][I_X-1:0]            colv;
  logic [K-1:0][K-1:0][I_X-1:0]     win_q;

  logic [NT-1:0][I_W-1:0] shadow_q, wact_q;
  logic                   relu_q, relu_s1_q;
  logic [NT-1:0][PW-1:0]  prod_d, prod_q;
  logic signed [PW-1:0]   xa, wa;
  logic signed [ACC_W-1:0] acc;
  logic signed [EXT_W-1:0] ext;
  logic [O_SAT-1:0]       y_d, y_q;
  logic [STAGES:0]        vld_pipe_q, last_pipe_q;

  assign oY         = y_q;
  assign oValid     = vld_pipe_q[STAGES];
  assign oFrameDone = last_pipe_q[STAGES];

  // pixel position (iSOF forces origin) and next counter state
  always_comb begin
    pos_r       = iSOF ? '0 : row_q;
    pos_c       = iSOF ? '0 : col_q;
    frame_start = iValid && (pos_r == '0) && (pos_c == '0);
    win_pos     = (pos_r >= RW'(K-1)) && (pos_c >= CW'(K-1));
    last_pos    = (pos_r == RW'(IMG_H-1)) && (pos_c == CW'(IMG_W-1));
    row_d       = row_q;
    col_d       = col_q;
    if (iValid) begin
      if (pos_c == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (pos_r == RW'(IMG_H-1)) ? '0 : pos_r + RW'(1);
      end else begin
        col_d = pos_c + CW'(1);
        row_d = pos_r;
      end
    end
  end

  // new window column: incoming pixel at the bottom, older rows from line taps
  always_comb begin
    line_in    = '0;
    colv       = '0;
    line_in[0] = iX;
    for (int m = 1; m < K-1; m++) line_in[m] = line_q[m-1][IMG_W-1];
    colv[K-1] = iX;
    for (int i = 0; i < K-1; i++) colv[i] = line_q[K-2-i][IMG_W-1];
  end

  // per-tap signed products; window column j lives at win_q[i][K-1-j]
  always_comb begin
    prod_d = '0;
    xa     = '0;
    wa     = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        xa = {{(PW-I_X){win_q[i][K-1-j][I_X-1]}}, win_q[i][K-1-j]};
        wa = {{(PW-I_W){wact_q[i*K+j][I_W-1]}}, wact_q[i*K+j]};
        prod_d[i*K+j] = xa * wa;
      end
    end
  end

  // adder tree, saturation, then optional ReLU
  always_comb begin
    acc = '0;
    for (int t = 0; t < NT; t++) acc = acc + {{(ACC_W-PW){prod_q[t][PW-1]}}, prod_q[t]};
    ext = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc};
    if (ext > SMAX)      y_d = SMAX[O_SAT-1:0];
    else if (ext < SMIN) y_d = SMIN[O_SAT-1:0];
    else                 y_d = ext[O_SAT-1:0];
    if (relu_s1_q && y_d[O_SAT-1]) y_d = '0;
  end

  // counters, line buffers and window advance only on accepted pixels
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      row_q  <= '0;
      col_q  <= '0;
      line_q <= '0;
      win_q  <= '0;
    end else if (iValid) begin
      row_q <= row_d;
      col_q <= col_d;
      for (int m = 0; m < K-1; m++) line_q[m] <= {line_q[m][IMG_W-2:0], line_in[m]};
      for (int i = 0; i < K; i++)   win_q[i]  <= {win_q[i][K-2:0], colv[i]};
    end
  end

  // weight banks: active takes the pre-write shadow at frame start
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      shadow_q <= '0;
      wact_q   <= '0;
      relu_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        wact_q <= shadow_q;
        relu_q <= iRelu;
      end
      if (iWren && ({1'b0, iADDR} < (ADDR_W+1)'(NT))) shadow_q[iADDR] <= iW;
    end
  end

  // two compute stages with valid/last shift registers
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      prod_q      <= '0;
      relu_s1_q   <= 1'b0;
      y_q         <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      prod_q      <= prod_d;
      relu_s1_q   <= relu_q;
      vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], iValid && win_pos};
      last_pipe_q <= {last_pipe_q[STAGES-1:0], iValid && win_pos && last_pos};
      if (vld_pipe_q[STAGES-1]) y_q <= y_d;
    end
  end
endmodule

// File: tb/tb_conv2d_kxk_stream.sv
// Bench for conv2d_kxk_stream at K=3, 6x6 image: a frame-level model
// (image array, weight banks, per-window sums) feeds an expectation queue
// that a negedge process checks every cycle; literals pin key results.
module tb_conv2d_kxk_stream;
  localparam int K = 3, N = 6;

  logic iCLK = 0, iRSTn = 0;
  logic [7:0] iW = 0, iX = 0;
  logic [4:0] iADDR = 0;
  logic iWren = 0, iValid = 0, iSOF = 0, iRelu = 0;
  logic signed [15:0] oY;
  logic oValid, oFrameDone;

  conv2d_kxk_stream #(.K(K), .IMG_W(N), .IMG_H(N), .I_X(8), .I_W(8), .O_SAT(16), .ADDR_W(5)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iW(iW), .iADDR(iADDR), .iWren(iWren), .iX(iX),
    .iValid(iValid), .iSOF(iSOF), .iRelu(iRelu), .oY(oY), .oValid(oValid), .oFrameDone(oFrameDone));

  always #5 iCLK = ~iCLK;

  int total = 0, bad = 0, edge_n = 0;
  always @(posedge iCLK) edge_n <= edge_n + 1;

  typedef struct { int e; longint y; bit done; } exp_t;
  exp_t q[$];

  longint shadow[K*K], act[K*K], img[N][N], pimg[N][N];
  bit m_relu = 0;
  int m_r = 0, m_c = 0;

  longint hold_y = 0, last_y = 0;
  int res_cnt = 0, frame_cnt = 0, first_e = 0, fs_edge = 0;
  logic ev;

  task automatic chk(string nm, longint a, longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, a, e, edge_n);
    end
  endtask

  // frame-level model of one clock with the given inputs
  task automatic model_step(bit v, longint x, bit sof, bit relu, bit we, int addr, longint w);
    longint s;
    exp_t en;
    if (v) begin
      if (sof) begin m_r = 0; m_c = 0; end
      if (m_r == 0 && m_c == 0) begin
        for (int k = 0; k < K*K; k++) act[k] = shadow[k];
        m_relu = relu;
      end
    end
    if (we && addr < K*K) shadow[addr] = w;
    if (v) begin
      img[m_r][m_c] = x;
      if (m_r >= K-1 && m_c >= K-1) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += act[i*K+j] * img[m_r-K+1+i][m_c-K+1+j];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (m_relu && s < 0) s = 0;
        en.e = edge_n + 2; en.y = s; en.done = (m_r == N-1 && m_c == N-1);
        q.push_back(en);
      end
      if (m_c == N-1) begin m_c = 0; m_r = (m_r == N-1) ? 0 : m_r + 1; end
      else m_c++;
    end
  endtask

  task automatic step(bit v, longint x, bit sof, bit relu, bit we, int addr, longint w);
    longint xv = x, wv = w;
    int av = addr;
    iValid = v; iX = xv[7:0]; iSOF = sof; iRelu = relu; iWren = we; iADDR = av[4:0]; iW = wv[7:0];
    @(posedge iCLK); #1;
    model_step(v, x, sof, relu, we, addr, w);
    iValid = 0; iSOF = 0; iWren = 0;
  endtask

  task automatic load_all(longint v);
    for (int k = 0; k < K*K; k++) step(0, 0, 0, 0, 1, k, v);
  endtask

  task automatic fill(longint v);
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) pimg[r][c] = v;
  endtask

  // npix pixels of pimg; optional weight writes from pixel wr_at on
  task automatic send_frame(int duty, bit relu, bit sof0, int wr_at, int wr_base, int wr_n,
                            longint wr_val, int npix, int tail);
    int r, c, nb;
    fs_edge = edge_n + 1;
    for (int idx = 0; idx < npix; idx++) begin
      nb = 0;
      while (duty < 100 && int'($urandom_range(99)) >= duty && nb < 10) begin
        step(0, 0, 0, 0, 0, 0, 0); nb++;
      end
      r = idx / N; c = idx % N;
      step(1, pimg[r][c], idx == 0 && sof0, (idx == 0) ? relu : 1'($urandom_range(1)),
           idx >= wr_at && idx < wr_at + wr_n, wr_base + idx - wr_at, wr_val);
    end
    for (int t = 0; t < tail; t++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // cycle-by-cycle compare against the model queue
  always @(negedge iCLK) begin
    if (iRSTn) begin
      ev = (q.size() > 0) && (q[0].e == edge_n);
      chk("oValid", oValid, ev);
      if (ev) begin
        chk("oY", oY, q[0].y);
        chk("oFrameDone", oFrameDone, q[0].done);
        if (res_cnt == 0) first_e = edge_n;
        res_cnt++;
        last_y = oY;
        if (oFrameDone) begin frame_cnt = res_cnt; res_cnt = 0; end
        void'(q.pop_front());
      end else begin
        chk("oY_hold", oY, hold_y);
        chk("oFrameDone_idle", oFrameDone, 0);
      end
      if (oValid) hold_y = oY;
    end
  end

  initial begin
    for (int k = 0; k < K*K; k++) begin shadow[k] = 0; act[k] = 0; end
    #12;
    chk("rst_oY", oY, 0); chk("rst_oValid", oValid, 0); chk("rst_oFrameDone", oFrameDone, 0);
    @(negedge iCLK); #2 iRSTn = 1;

    // basic: all ones
    load_all(1); fill(1);
    send_frame(100, 0, 1, 99, 0, 0, 0, 36, 3);
    chk("ones_y", last_y, 9); chk("ones_cnt", frame_cnt, 16);
    chk("first_latency", first_e - fs_edge, 16);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 0);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);
    chk("b2b_y", last_y, 9); chk("b2b_cnt", frame_cnt, 16);

    // double-buffered weights
    send_frame(100, 0, 0, 10, 0, 9, 2, 36, 3);  chk("dbuf_cur", last_y, 9);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("dbuf_next", last_y, 18);
    send_frame(100, 0, 0, 0, 0, 1, 5, 36, 3);   chk("fs_write_cur", last_y, 18);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("fs_write_next", last_y, 21);
    for (int a = 9; a < 32; a++) step(0, 0, 0, 0, 1, a, 100);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("oob_ignored", last_y, 21);

    // saturation
    load_all(127); fill(127);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("sat_pos", last_y, 32767);
    load_all(-128);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("sat_neg", last_y, -32768);

    // ReLU captured at frame start
    load_all(-1); fill(1);
    send_frame(100, 1, 0, 99, 0, 0, 0, 36, 3);  chk("relu_on", last_y, 0);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("relu_off", last_y, -9);

    // ramp image with bubbles
    for (int k = 0; k < K*K; k++) step(0, 0, 0, 0, 1, k, k - 4);
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) pimg[r][c] = r*N + c - 10;
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("ramp_y", last_y, 114);
    send_frame(30, 0, 0, 99, 0, 0, 0, 36, 3);   chk("ramp_d30", last_y, 114); chk("cnt_d30", frame_cnt, 16);
    send_frame(60, 0, 0, 99, 0, 0, 0, 36, 3);   chk("cnt_d60", frame_cnt, 16);
    send_frame(85, 0, 0, 99, 0, 0, 0, 36, 3);   chk("cnt_d85", frame_cnt, 16);

    // irregular image, then resync via iSOF at pixel 20
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) pimg[r][c] = ((r*37 + c*11 + r*c*5) % 41) - 20;
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);
    send_frame(50, 0, 0, 99, 0, 0, 0, 36, 3);
    send_frame(100, 0, 0, 99, 0, 0, 0, 20, 3);
    res_cnt = 0;
    send_frame(70, 0, 1, 99, 0, 0, 0, 36, 3);   chk("resync_cnt", frame_cnt, 16);

    // reset mid-frame
    send_frame(100, 0, 0, 99, 0, 0, 0, 15, 0);
    iRSTn = 0; #1;
    chk("midrst_oY", oY, 0); chk("midrst_oValid", oValid, 0); chk("midrst_done", oFrameDone, 0);
    for (int k = 0; k < K*K; k++) begin shadow[k] = 0; act[k] = 0; end
    m_r = 0; m_c = 0; m_relu = 0; q.delete();
    hold_y = 0; last_y = 99; res_cnt = 0; frame_cnt = 0;
    @(negedge iCLK); #2 iRSTn = 1;
    fill(1);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("rst_w0_y", last_y, 0); chk("rst_cnt", frame_cnt, 16);
    load_all(1);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);
    send_frame(100, 0, 0, 99, 0, 0, 0, 36, 3);  chk("reload_y", last_y, 9);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
